i2c_eeprom_target: RTL and testbench

I2C responder (target) that emulates a small byte-addressed EEPROM behind a fixed 7-bit device address. It is the bus-side counterpart to the team's I2C initiator and sits at the board-model / FPGA-pin side of an I2C link. The block oversamples SCL/SDA with the system clock, detects START/STOP, ACKs matching address and write bytes, and serves reads from an internal register array with auto-incrementing pointer.

---
 rtl/i2c_pkg.sv | 32 +++
 rtl/i2c_line_sync.sv | 49 ++++
 rtl/i2c_eeprom_target.sv | 243 ++++++++++++++++++++++++
 tb/tb_i2c_eeprom_target.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
// i2c_pkg: shared definitions for the I2C EEPROM target.
//   - i2c_state_e   : target protocol state encoding
//   - SDA_ACK/NACK  : SDA line level for acknowledge / not-acknowledge
//   - I2C_DEV_ADDR_DEFAULT : default 7-bit device address
//   - bit_index()   : maps a serial bit position to a byte bit index
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_PTR      = 4'd3,
    ST_PTR_ACK  = 4'd4,
    ST_WR_BYTE  = 4'd5,
    ST_WR_ACK   = 4'd6,
    ST_RD_BYTE  = 4'd7,
    ST_RD_ACK   = 4'd8,
    ST_IGNORE   = 4'd9
  } i2c_state_e;

  localparam logic SDA_ACK  = 1'b0;
  localparam logic SDA_NACK = 1'b1;

  localparam logic [6:0] I2C_DEV_ADDR_DEFAULT = 7'h50;

  // Serial position n (0 = first bit on the wire) -> bit index in the byte.
  function automatic logic [2:0] bit_index(input logic [2:0] n, input logic lsb_first);
    return lsb_first ? n : (3'd7 - n);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
`timescale 1ns/1ps
// i2c_line_sync: brings asynchronous SCL/SDA into the clk domain and
// derives bus events.
// Ports:
//   clk_i       system clock (>= 8x SCL)
//   rst_ni      asynchronous active-low reset (synchronizers load 1 = idle bus)
//   scl_i/sda_i raw bus line levels
//   sda_o       synchronized SDA level
//   scl_rise_o  one-cycle pulse on synchronized SCL rising edge
//   scl_fall_o  one-cycle pulse on synchronized SCL falling edge
//   start_o     START / repeated START (SDA falls while SCL high)
//   stop_o      STOP (SDA rises while SCL high)
module i2c_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // [0],[1] form the 2-FF synchronizer; [2] is the previous synced value.
  logic [2:0] scl_q;
  logic [2:0] sda_q;
  logic       sda_rise;
  logic       sda_fall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_o      = sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  assign sda_rise   = sda_q[1] & ~sda_q[2];
  assign sda_fall   = ~sda_q[1] & sda_q[2];
  assign start_o    = sda_fall & scl_q[1];
  assign stop_o     = sda_rise & scl_q[1];

endmodule

// File: rtl/i2c_eeprom_target.sv
`timescale 1ns/1ps
// i2c_eeprom_target: I2C target emulating a small byte-addressed EEPROM.
// Write: START, addr+W, pointer, data... STOP. Read: START, addr+R, data...
// (optionally preceded by a pointer-setting write and repeated START).
// The pointer auto-increments and wraps at MEM_DEPTH.
// Ports:
//   clk      system clock (>= 8x SCL)
//   rst      asynchronous active-low reset
//   scl_i    SCL line level (async)
//   sda_i    SDA line level (async)
//   sda_oe   1 = pull SDA low (open-drain)
//   wr_stb   one-cycle pulse when a data byte is committed
//   wr_addr  location written on wr_stb
//   wr_data  byte written on wr_stb
//   busy     high from address match until STOP or next START
module i2c_eeprom_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = I2C_DEV_ADDR_DEFAULT,
  parameter int         MEM_DEPTH = 16,
  parameter bit         LSB_FIRST = 1'b0,
  localparam int        AW        = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_line_sync u_sync (
    .clk_i      (clk),
    .rst_ni     (rst),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  i2c_state_e    state_q, state_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          rw_q, rw_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          ack_drv_q, ack_drv_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          wr_stb_q, wr_stb_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    mem_q [MEM_DEPTH];
  logic          mem_we;

  logic [7:0]    rx_byte;
  logic [6:0]    rx_addr;
  logic          rx_rw;
  logic [7:0]    rd_byte;
  logic [2:0]    rd_idx;
  logic          rd_bit0;

  // Byte as it will stand once the current SDA sample is shifted in; after
  // eight samples it is in natural bit order for either wire order.
  assign rx_byte = LSB_FIRST ? {sda_s, shreg_q[7:1]} : {shreg_q[6:0], sda_s};
  // R/W is the eighth bit on the wire, the address the first seven.
  assign rx_addr = LSB_FIRST ? rx_byte[6:0] : rx_byte[7:1];
  assign rx_rw   = LSB_FIRST ? rx_byte[7]   : rx_byte[0];

  assign rd_byte = mem_q[ptr_q];
  assign rd_idx  = bit_index(bitcnt_q[2:0], LSB_FIRST);
  assign rd_bit0 = rd_byte[bit_index(3'd0, LSB_FIRST)];

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    ack_drv_d = ack_drv_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;

    if (stop_det) begin
      state_d   = ST_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      ack_drv_d = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      bitcnt_d  = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      ack_drv_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_IGNORE: begin
        end

        ST_ADDR, ST_PTR, ST_WR_BYTE: begin
          if (scl_rise) begin
            shreg_d  = rx_byte;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              bitcnt_d = 4'd0;
              if (state_q == ST_ADDR) begin
                if (rx_addr == DEV_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  rw_d    = rx_rw;
                  busy_d  = 1'b1;
                end else begin
                  state_d = ST_IGNORE;
                end
              end else if (state_q == ST_PTR) begin
                ptr_d   = rx_byte[AW-1:0];
                state_d = ST_PTR_ACK;
              end else begin
                mem_we    = 1'b1;
                wr_stb_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = rx_byte;
                ptr_d     = ptr_q + 1'b1;
                state_d   = ST_WR_ACK;
              end
            end
          end
        end

        // First SCL fall after the byte pulls SDA low for the ACK clock;
        // the next fall releases it and moves on.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              sda_oe_d  = (SDA_ACK == 1'b0);
              ack_drv_d = 1'b1;
            end else begin
              ack_drv_d = 1'b0;
              sda_oe_d  = 1'b0;
              bitcnt_d  = 4'd0;
              if (state_q == ST_ADDR_ACK) begin
                if (rw_q) begin
                  // The first read bit goes out on the same fall that ends the ACK.
                  state_d  = ST_RD_BYTE;
                  sda_oe_d = ~rd_bit0;
                  bitcnt_d = 4'd1;
                end else begin
                  state_d = ST_PTR;
                end
              end else begin
                state_d = ST_WR_BYTE;
              end
            end
          end
        end

        // bitcnt counts bits already put on the wire; at 8 the byte is done.
        ST_RD_BYTE: begin
          if (scl_fall) begin
            if (!bitcnt_q[3]) begin
              sda_oe_d = ~rd_byte[rd_idx];
              bitcnt_d = bitcnt_q + 4'd1;
            end else begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + 1'b1;
              state_d  = ST_RD_ACK;
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == SDA_ACK) begin
              state_d  = ST_RD_BYTE;
              bitcnt_d = 4'd0;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      bitcnt_q  <= 4'd0;
      shreg_q   <= 8'h00;
      rw_q      <= 1'b0;
      ptr_q     <= '0;
      ack_drv_q <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      rw_q      <= rw_d;
      ptr_q     <= ptr_d;
      ack_drv_q <= ack_drv_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (mem_we) begin
      mem_q[ptr_q] <= rx_byte;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_i2c_eeprom_target.sv
`timescale 1ns/1ps
module tb_i2c_eeprom_target;

  localparam logic [6:0] DEV   = 7'h50;
  localparam int         DEPTH = 16;
  localparam bit         LSBF  = 1'b0;
  localparam int         AW    = $clog2(DEPTH);
  localparam int         Q     = 40;  // quarter SCL period in ns (SCL = 160 ns, clk = 10 ns)

  typedef logic [7:0] bytes_t [$];
  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          scl = 1'b1;
  logic          sda_m = 1'b1;
  logic          sda_line;
  logic          sda_oe;
  logic          wr_stb;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;

  // Open-drain wired-AND of master and target
  assign sda_line = sda_m & ~sda_oe;

  i2c_eeprom_target #(
    .DEV_ADDR  (DEV),
    .MEM_DEPTH (DEPTH),
    .LSB_FIRST (LSBF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (scl),
    .sda_i   (sda_line),
    .sda_oe  (sda_oe),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Reference model: EEPROM contents and pointer
  logic [7:0]  mem_m [DEPTH];
  int          ptr_m = 0;

  exp_t        bus_exp [$];
  logic [7:0]  bus_act [$];
  logic [15:0] wr_exp  [$];
  logic [15:0] wmon;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  initial begin
    exp_t       e;
    logic [7:0] a;
    forever begin
      @(negedge clk);
      while (bus_act.size() > 0) begin
        a = bus_act.pop_front();
        if (bus_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got %0h with no response required", a);
        end else begin
          e = bus_exp.pop_front();
          check(e.tag, 32'(a), 32'(e.val));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && wr_stb) begin
      if (wr_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got addr=%0d data=%02h, no write required", wr_addr, wr_data);
      end else begin
        wmon = wr_exp.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(wmon[15:8]));
        check("wr_data", 32'(wr_data), 32'(wmon[7:0]));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, got timeout required finish");
    $fatal(1, "timeout");
  end

  // ---------------- bus master ----------------
  function automatic logic [7:0] abyte(input logic [6:0] a, input logic rw);
    return LSBF ? {rw, a} : {a, rw};
  endfunction

  function automatic int widx(input int i);
    return LSBF ? i : 7 - i;
  endfunction

  // Each bit starts a quarter period after SCL fell.
  task automatic bit_io(input logic b, output logic r);
    sda_m = b;
    #(Q); scl = 1'b1;
    #(Q); r = sda_line;
    #(Q); scl = 1'b0;
    #(Q);
  endtask

  task automatic start_c();
    sda_m = 1'b1; scl = 1'b1;
    #(Q); sda_m = 1'b0;
    #(Q); scl = 1'b0;
    #(Q);
  endtask

  task automatic rstart_c();
    sda_m = 1'b1;
    #(Q); scl = 1'b1;
    #(Q); sda_m = 1'b0;
    #(Q); scl = 1'b0;
    #(Q);
  endtask

  task automatic stop_c();
    sda_m = 1'b0;
    #(Q); scl = 1'b1;
    #(Q); sda_m = 1'b1;
    #(2*Q);
  endtask

  task automatic expect_bus(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    bus_exp.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] v, input string tag, input logic [7:0] exp_ack);
    logic r;
    expect_bus(tag, exp_ack);
    for (int i = 0; i < 8; i++) bit_io(v[widx(i)], r);
    bit_io(1'b1, r);
    bus_act.push_back({7'd0, r});
  endtask

  task automatic recv_byte(input logic mack, input string tag);
    logic       r;
    logic [7:0] v;
    expect_bus(tag, mem_m[ptr_m]);
    ptr_m = (ptr_m + 1) % DEPTH;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_io(1'b1, r);
      v[widx(i)] = r;
    end
    bus_act.push_back(v);
    bit_io(mack, r);
  endtask

  // ---------------- transaction-level model + stimulus ----------------
  task automatic do_write(input logic [6:0] a, input logic [7:0] p, input bytes_t d);
    logic       hit;
    logic [7:0] ack;
    hit = (a == DEV);
    ack = hit ? 8'd0 : 8'd1;
    start_c();
    send_byte(abyte(a, 1'b0), "addr_w_ack", ack);
    check(hit ? "busy_after_match" : "busy_no_match", 32'(busy), 32'(hit));
    send_byte(p, "ptr_ack", ack);
    if (hit) ptr_m = p % DEPTH;
    foreach (d[i]) begin
      if (hit) begin
        wr_exp.push_back({8'(ptr_m), d[i]});
        mem_m[ptr_m] = d[i];
        ptr_m = (ptr_m + 1) % DEPTH;
      end
      send_byte(d[i], "data_ack", ack);
    end
    if (!hit) check("sda_oe_no_match", 32'(sda_oe), 32'd0);
    stop_c();
    check("busy_after_stop", 32'(busy), 32'd0);
  endtask

  task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n);
    start_c();
    if (set_ptr) begin
      send_byte(abyte(DEV, 1'b0), "addr_w_ack", 8'd0);
      send_byte(p, "ptr_ack", 8'd0);
      ptr_m = p % DEPTH;
      rstart_c();
    end
    send_byte(abyte(DEV, 1'b1), "addr_r_ack", 8'd0);
    for (int k = 0; k < n; k++) recv_byte(k == n - 1, "rd_byte");
    check("sda_released_after_nack", 32'(sda_oe), 32'd0);
    stop_c();
    check("busy_after_read_stop", 32'(busy), 32'd0);
  endtask

  task automatic do_partial(input logic [7:0] p, input int nbits);
    logic r;
    start_c();
    send_byte(abyte(DEV, 1'b0), "addr_w_ack", 8'd0);
    send_byte(p, "ptr_ack", 8'd0);
    ptr_m = p % DEPTH;
    for (int i = 0; i < nbits; i++) bit_io(1'($urandom_range(0, 1)), r);
    stop_c();
    check("busy_after_partial", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [6:0] ra;
    bytes_t     d;
    int         op;

    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;

    #20;
    check("rst_sda_oe",  32'(sda_oe),  32'd0);
    check("rst_wr_stb",  32'(wr_stb),  32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    rst = 1'b1;
    #(4*Q);

    // directed: write, random read, mismatch, wrap, partial byte
    d = '{8'h5A, 8'hC3};
    do_write(DEV, 8'h03, d);
    do_read(1'b1, 8'h03, 2);
    d = '{};
    do_write(7'h51, 8'h11, d);
    d = '{8'h11, 8'h22};
    do_write(DEV, 8'h0F, d);
    do_read(1'b1, 8'h0F, 2);
    do_partial(8'h07, 4);
    d = '{8'h99};
    do_write(DEV, 8'h08, d);
    do_read(1'b0, 8'h00, 2);   // current-address read continues from pointer

    // randomized mix
    for (int it = 0; it < 16; it++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          d = '{};
          for (int k = 0; k < $urandom_range(0, 3); k++) d.push_back(8'($urandom));
          do_write(DEV, 8'($urandom), d);
        end
        1: do_read(1'b1, 8'($urandom), $urandom_range(1, 3));
        2: do_read(1'b0, 8'h00, $urandom_range(1, 3));
        default: begin
          ra = 7'($urandom);
          if (ra == DEV) ra = ra ^ 7'h01;
          d = '{8'($urandom)};
          do_write(ra, 8'($urandom), d);
        end
      endcase
    end

    // asynchronous reset while the target is driving a 0 read bit
    d = '{8'h00};
    do_write(DEV, 8'h05, d);
    start_c();
    send_byte(abyte(DEV, 1'b0), "addr_w_ack", 8'd0);
    send_byte(8'h05, "ptr_ack", 8'd0);
    rstart_c();
    send_byte(abyte(DEV, 1'b1), "addr_r_ack", 8'd0);
    #20;
    check("rd_drive_zero", 32'(sda_oe), 32'd1);
    rst = 1'b0;
    #1;
    check("async_rst_sda_oe", 32'(sda_oe), 32'd0);
    check("async_rst_busy",   32'(busy),   32'd0);
    sda_m = 1'b1;
    scl   = 1'b1;
    #(2*Q);
    rst = 1'b1;
    #(4*Q);
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    ptr_m = 0;
    do_read(1'b1, 8'h03, 2);
    do_read(1'b1, 8'h0F, 2);

    repeat (10) @(posedge clk);
    check("wr_scoreboard_drained",  32'(wr_exp.size()),  32'd0);
    check("bus_scoreboard_drained", 32'(bus_exp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
